// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline definitions for the ID/EX stage: default widths,
// ALUOp class encodings and the packed control bundle carried ID -> EX.
package id_ex_hazard_reg_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,  // address calc / load / store
    ALUOP_BRANCH = 2'b01,  // subtract for branch compare
    ALUOP_FUNCT  = 2'b10   // R-type, decoded from funct
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // A bubble carries no side effects: no register write, no memory access.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX stage bus: ID-side fields and Flush in, EX-side fields and Stall out.
// master = pipeline driving ID and consuming EX; slave = the ID/EX register.
interface id_ex_hazard_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              ID_Valid;
  logic [REG_AW-1:0] ID_RS, ID_RT, ID_RD;
  logic              ID_UsesRT;
  logic [DATA_W-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic              ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst;
  logic [1:0]        ID_ALUOp;
  logic              Flush;

  logic              EX_Valid;
  logic [REG_AW-1:0] EX_RS, EX_RT, EX_RD;
  logic [DATA_W-1:0] EX_ReadData1, EX_ReadData2, EX_Imm;
  logic              EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst;
  logic [1:0]        EX_ALUOp;
  logic              Stall;

  modport master (
    output ID_Valid, ID_RS, ID_RT, ID_RD, ID_UsesRT, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst, ID_ALUOp,
           Flush,
    input  EX_Valid, EX_RS, EX_RT, EX_RD, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst, EX_ALUOp,
           Stall
  );

  modport slave (
    input  ID_Valid, ID_RS, ID_RT, ID_RD, ID_UsesRT, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst, ID_ALUOp,
           Flush,
    output EX_Valid, EX_RS, EX_RT, EX_RD, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst, EX_ALUOp,
           Stall
  );
endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Load-use hazard: a valid load in EX whose destination (RT, never $0)
// is a source of the valid instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);

  logic rs_match, rt_match;

  // Source match against the load destination; RT only counts when read.
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt && (ex_rt == id_rt);
    hazard   = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Optional build macro IDEX_PERF_CNT_EN adds saturating StallCount/FlushCount.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  id_ex_hazard_reg_if.slave  pif
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]        StallCount,
  output logic [31:0]        FlushCount
`endif
);

  logic              hazard;
  ctrl_t             id_ctrl, ex_ctrl;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;

  assign id_ctrl = '{reg_write:  pif.ID_RegWrite,
                     mem_read:   pif.ID_MemRead,
                     mem_write:  pif.ID_MemWrite,
                     mem_to_reg: pif.ID_MemToReg,
                     alu_src:    pif.ID_ALUSrc,
                     reg_dst:    pif.ID_RegDst,
                     alu_op:     pif.ID_ALUOp};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (ex_rt),
    .id_valid    (pif.ID_Valid),
    .id_rs       (pif.ID_RS),
    .id_rt       (pif.ID_RT),
    .id_uses_rt  (pif.ID_UsesRT),
    .hazard      (hazard)
  );

  // Stage register: flush beats hazard, both load an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= CTRL_BUBBLE;
    end else if (pif.Flush || hazard) begin
      ex_valid <= 1'b0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= CTRL_BUBBLE;
    end else begin
      ex_valid <= pif.ID_Valid;
      ex_rs    <= pif.ID_RS;
      ex_rt    <= pif.ID_RT;
      ex_rd    <= pif.ID_RD;
      ex_rd1   <= pif.ID_ReadData1;
      ex_rd2   <= pif.ID_ReadData2;
      ex_imm   <= pif.ID_Imm;
      ex_ctrl  <= id_ctrl;
    end
  end

  assign pif.EX_Valid     = ex_valid;
  assign pif.EX_RS        = ex_rs;
  assign pif.EX_RT        = ex_rt;
  assign pif.EX_RD        = ex_rd;
  assign pif.EX_ReadData1 = ex_rd1;
  assign pif.EX_ReadData2 = ex_rd2;
  assign pif.EX_Imm       = ex_imm;
  assign pif.EX_RegWrite  = ex_ctrl.reg_write;
  assign pif.EX_MemRead   = ex_ctrl.mem_read;
  assign pif.EX_MemWrite  = ex_ctrl.mem_write;
  assign pif.EX_MemToReg  = ex_ctrl.mem_to_reg;
  assign pif.EX_ALUSrc    = ex_ctrl.alu_src;
  assign pif.EX_RegDst    = ex_ctrl.reg_dst;
  assign pif.EX_ALUOp     = ex_ctrl.alu_op;

  // A taken branch squashes the ID instruction, so no stall is needed then.
  assign pif.Stall = hazard && !pif.Flush;

`ifdef IDEX_PERF_CNT_EN
  // Saturating event counters for stall cycles and squashed valid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (pif.Stall && (StallCount != '1)) StallCount <= StallCount + 32'd1;
      if (pif.Flush && pif.ID_Valid && (FlushCount != '1)) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection and branch flush. It captures decoded operands, register specifiers and control bits from ID and presents them to EX. Its EX_RS/EX_RT outputs drive the forwarding unit directly. It stalls PC and IF/ID and inserts a bubble when an EX-stage load feeds the ID instruction. It squashes the ID instruction on a taken branch.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register specifier width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ID_Valid  in  1  ID holds a real instruction
ID_RS, ID_RT, ID_RD  in  REG_AW each  decoded specifiers
ID_UsesRT  in  1  instruction reads RT as a source (R-type, store, branch)
ID_ReadData1, ID_ReadData2  in  DATA_W each  register file outputs
ID_Imm  in  DATA_W  sign-extended immediate
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst  in  1 each  control
ID_ALUOp  in  2  ALU op class
Flush  in  1  taken branch resolved in EX; squash ID
EX_Valid  out  1  registered valid
EX_RS, EX_RT, EX_RD  out  REG_AW each  registered specifiers
EX_ReadData1, EX_ReadData2, EX_Imm  out  DATA_W each  registered data
EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst  out  1 each  registered control
EX_ALUOp  out  2  registered ALU op
Stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Assertion clears every registered output to 0 immediately, without waiting for a clock edge. Stall therefore reads 0 during reset.
- Hazard: Hazard = EX_Valid & EX_MemRead & ID_Valid & (EX_RT != 0) & ((EX_RT == ID_RS) | (ID_UsesRT & EX_RT == ID_RT)).
- Stall = Hazard & ~Flush. Stall is purely combinational from the current register state and ID inputs.
- Each rising edge applies the first matching case, in priority order:
  1. Flush=1: load a bubble. Flush overrides a concurrent hazard.
  2. Hazard=1: load a bubble. The ID instruction is held upstream and re-presented next cycle.
  3. Otherwise: capture all ID_* fields; EX_Valid <= ID_Valid.
- Bubble: every EX_* output is 0, including specifiers and data. A zero EX_RS/EX_RT never matches in forwarding, and zero control produces no write.
- ID_Valid=0 with no flush and no hazard: the fields are captured as presented and EX_Valid=0. Upstream guarantees zero control on invalid slots.
- Latency: 1 cycle from ID to EX. A load-use pair costs exactly one bubble. After the bubble, EX_MemRead=0, so Hazard deasserts and the held instruction passes on the next edge.
- Back-to-back loads each feeding the next instruction: one bubble per pair, never two consecutive stall cycles for the same ID instruction.
- Hazard on RS when EX_RT=0: no stall, because $0 is excluded.
- Reset deasserted mid-stream: the first edge after release behaves normally; no spurious bubble.

Optional Feature:
IDEX_PERF_CNT_EN
- Defined: adds two outputs, StallCount[31:0] and FlushCount[31:0].
- StallCount increments on each edge where Stall=1. FlushCount increments on each edge where Flush=1 and ID_Valid=1.
- Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Shared pipeline package holds:
  - REG_AW and DATA_W defaults;
  - the ALUOp encodings (2'b00 add/mem, 2'b01 branch-sub, 2'b10 R-type funct);
  - a packed control-bundle typedef {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp} with its zero/bubble constant.
- One natural sub-module: load_use_detect, the combinational Hazard equation. The register and priority logic stay in the top.

Test Plan:
- Reset: drive random ID inputs with rst_n=0 -> all EX_* = 0 and Stall=0. Release -> the next edge captures ID_RS=3, ID_Imm=0x0000_0010.
- Load-use RS: EX holds lw with EX_RT=5 and MemRead=1; ID add with ID_RS=5 -> Stall=1. The next edge gives a bubble (EX_Valid=0, EX_RS=0). Stall=0 on the following cycle, and the add is captured one edge later.
- Load-use RT gating: EX lw with EX_RT=7; ID addi with ID_RT=7 and ID_UsesRT=0 -> Stall=0, no bubble. Repeat with ID_UsesRT=1 -> Stall=1.
- $0 exclusion: EX lw with EX_RT=0; ID_RS=0 -> Stall=0.
- Flush vs hazard: hazard conditions true and Flush=1 in the same cycle -> Stall=0, bubble loaded. With IDEX_PERF_CNT_EN defined: FlushCount +1, StallCount unchanged.
- Counter saturation (IDEX_PERF_CNT_EN defined): force StallCount to 0xFFFF_FFFE, then apply 3 stall cycles -> StallCount reads 0xFFFF_FFFF.
